// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the hazard/forwarding controller
//
// Purpose: scoreboard slot record, forwarding-select type, FSM state encoding and
// default geometry of the in-order pipeline (slot0=E, slot1=M, slot2=W).
// Ports: none (package).
package hazard_pkg;

    localparam int HZ_AW        = 5;
    localparam int HZ_NUM_SLOTS = 3;
    localparam int HZ_LOAD_SLOT = 1;
    localparam int SEL_W        = $clog2(HZ_NUM_SLOTS + 1);

    typedef logic [SEL_W-1:0] fwd_sel_t;

    // Select value meaning "take the operand from the register file".
    localparam fwd_sel_t FWD_RF = '0;

    typedef struct packed {
        logic             valid;
        logic [HZ_AW-1:0] waddr;
        logic             reg_write;
        logic             is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    typedef enum logic {
        IDLE     = 1'b0,
        LU_STALL = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shadow scoreboard of in-flight register writers
//
// Purpose: shift register of slot_t records (slot0 = youngest) plus per-slot source
// match vectors for the D-stage operands.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   hold_i                keep every slot unchanged this cycle
//   insert_bubble_i       slot0 receives an empty record instead of d_slot_i
//   d_slot_i              record describing the D-stage instruction
//   addr1_i/addr2_i       D-stage source register addresses
//   use1_i/use2_i         source actually read (already qualified by D valid)
//   match1_o/match2_o     per-slot hit vectors for each source
//   is_load_o             per-slot load flag
import hazard_pkg::*;

module hazard_scoreboard #(
    parameter int NUM_SLOTS = HZ_NUM_SLOTS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 hold_i,
    input  logic                 insert_bubble_i,
    input  slot_t                d_slot_i,
    input  logic [HZ_AW-1:0]     addr1_i,
    input  logic [HZ_AW-1:0]     addr2_i,
    input  logic                 use1_i,
    input  logic                 use2_i,
    output logic [NUM_SLOTS-1:0] match1_o,
    output logic [NUM_SLOTS-1:0] match2_o,
    output logic [NUM_SLOTS-1:0] is_load_o
);

    slot_t [NUM_SLOTS-1:0] slots_q;
    logic  [NUM_SLOTS-1:0] writer;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slots_q <= '0;
        end else if (!hold_i) begin
            for (int k = NUM_SLOTS - 1; k > 0; k--) begin
                slots_q[k] <= slots_q[k-1];
            end
            slots_q[0] <= insert_bubble_i ? SLOT_EMPTY : d_slot_i;
        end
    end

    // x0 is hard-wired zero, so a writer targeting it never creates a dependency.
    always_comb begin
        writer    = '0;
        match1_o  = '0;
        match2_o  = '0;
        is_load_o = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            writer[k]    = slots_q[k].valid && slots_q[k].reg_write && (slots_q[k].waddr != '0);
            match1_o[k]  = writer[k] && use1_i && (addr1_i == slots_q[k].waddr);
            match2_o[k]  = writer[k] && use2_i && (addr2_i == slots_q[k].waddr);
            is_load_o[k] = slots_q[k].is_load;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard/forwarding controller for the in-order RV32 pipeline
//
// Purpose: compares the D-stage instruction with the in-flight writers, produces
// stall/bubble/flush/freeze controls and registered forwarding selects for E.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   d_valid_i                  D holds a real instruction
//   d_addr1_i/d_addr2_i        source registers, d_use1_i/d_use2_i source read
//   d_waddr_i, d_reg_write_i   destination register and write enable
//   d_mem_read_i/d_mem_write_i D is a load / a store (addr2 = store data)
//   e_br_taken_i               E redirects fetch
//   mem_busy_i                 DMEM not ready, whole pipe holds
//   stall_fd_o, bubble_e_o, flush_d_o, freeze_o   pipeline controls
//   fwd_a_sel_o/fwd_b_sel_o    E operand source: 0=regfile, k=result of slot k
//   fwd_mem_sel_o              store data in M taken from the W-stage load
import hazard_pkg::*;

module hazard_ctrl #(
    parameter int NUM_SLOTS = HZ_NUM_SLOTS,
    parameter int LOAD_SLOT = HZ_LOAD_SLOT,
    parameter int AW        = HZ_AW
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               d_valid_i,
    input  logic [AW-1:0]                      d_addr1_i,
    input  logic [AW-1:0]                      d_addr2_i,
    input  logic                               d_use1_i,
    input  logic                               d_use2_i,
    input  logic [AW-1:0]                      d_waddr_i,
    input  logic                               d_reg_write_i,
    input  logic                               d_mem_read_i,
    input  logic                               d_mem_write_i,
    input  logic                               e_br_taken_i,
    input  logic                               mem_busy_i,
    output logic                               stall_fd_o,
    output logic                               bubble_e_o,
    output logic                               flush_d_o,
    output logic                               freeze_o,
    output logic [$clog2(NUM_SLOTS+1)-1:0]     fwd_a_sel_o,
    output logic [$clog2(NUM_SLOTS+1)-1:0]     fwd_b_sel_o,
    output logic                               fwd_mem_sel_o
);

    localparam int SW = $clog2(NUM_SLOTS + 1);
    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = $clog2(LOAD_SLOT + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   fwd_a_q, fwd_b_q;
    logic            ldst_e_q, fwd_mem_q;

    slot_t           d_slot;
    logic [NUM_SLOTS-1:0] match1, match2, slot_load;

    logic            hit1, hit2;
    logic [IW-1:0]   idx1, idx2;
    logic            late1, late2, ldst, lu1, lu2, lu_hit;
    logic [CW-1:0]   lu_cycles;
    logic [SW-1:0]   sel_a, sel_b;
    logic            flush_req, advance, stall, bubble, flush;

    always_comb begin
        d_slot           = SLOT_EMPTY;
        d_slot.valid     = d_valid_i;
        d_slot.waddr     = d_waddr_i;
        d_slot.reg_write = d_reg_write_i;
        d_slot.is_load   = d_mem_read_i;
    end

    hazard_scoreboard #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_scoreboard (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .hold_i          (mem_busy_i),
        .insert_bubble_i (!advance),
        .d_slot_i        (d_slot),
        .addr1_i         (d_addr1_i),
        .addr2_i         (d_addr2_i),
        .use1_i          (d_use1_i && d_valid_i),
        .use2_i          (d_use2_i && d_valid_i),
        .match1_o        (match1),
        .match2_o        (match2),
        .is_load_o       (slot_load)
    );

    // Youngest writer wins: scan from oldest to youngest so the last hit sticks.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        idx1 = '0;
        idx2 = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (match1[k]) begin
                hit1 = 1'b1;
                idx1 = IW'(k);
            end
            if (match2[k]) begin
                hit2 = 1'b1;
                idx2 = IW'(k);
            end
        end
    end

    always_comb begin
        // A load's data exists only once it has passed LOAD_SLOT.
        late1 = hit1 && slot_load[idx1] && (int'(idx1) < LOAD_SLOT);
        late2 = hit2 && slot_load[idx2] && (int'(idx2) < LOAD_SLOT);
        // Store data is not needed until M, so a load right ahead can feed it late.
        ldst  = d_mem_write_i && hit2 && (idx2 == '0) && slot_load[0];
        lu1   = late1;
        lu2   = late2 && !ldst;
        lu_hit = lu1 || lu2;

        // The youngest late producer needs the most stall cycles.
        if (lu1 && (!lu2 || (idx1 <= idx2))) begin
            lu_cycles = CW'(LOAD_SLOT - int'(idx1));
        end else begin
            lu_cycles = CW'(LOAD_SLOT - int'(idx2));
        end

        // The last slot commits this cycle and the register file is write-first.
        sel_a = (hit1 && !late1 && (int'(idx1) < NUM_SLOTS - 1)) ? SW'(idx1) + SW'(1) : SW'(FWD_RF);
        sel_b = (hit2 && !late2 && (int'(idx2) < NUM_SLOTS - 1)) ? SW'(idx2) + SW'(1) : SW'(FWD_RF);
    end

    assign flush_req = e_br_taken_i && !mem_busy_i;

    // The detecting cycle is the first stall cycle; LU_STALL covers the remainder,
    // and once the count is spent the state falls through to a fresh evaluation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        flush   = 1'b0;
        advance = 1'b0;
        if (flush_req) begin
            flush   = 1'b1;
            bubble  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
        end else if ((state_q == LU_STALL) && (cnt_q != '0)) begin
            stall  = 1'b1;
            bubble = 1'b1;
            cnt_d  = cnt_q - CW'(1);
        end else if (lu_hit) begin
            stall   = 1'b1;
            bubble  = 1'b1;
            state_d = LU_STALL;
            cnt_d   = lu_cycles - CW'(1);
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
            advance = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fwd_a_q   <= SW'(FWD_RF);
            fwd_b_q   <= SW'(FWD_RF);
            ldst_e_q  <= 1'b0;
            fwd_mem_q <= 1'b0;
        end else if (!mem_busy_i) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            // A bubble entering E forwards nothing.
            fwd_a_q   <= advance ? sel_a : SW'(FWD_RF);
            fwd_b_q   <= advance ? sel_b : SW'(FWD_RF);
            // Two-stage delay lands the load->store select in the store's M cycle.
            ldst_e_q  <= advance && ldst;
            fwd_mem_q <= ldst_e_q;
        end
    end

    assign freeze_o      = mem_busy_i && !rst_i;
    assign stall_fd_o    = stall  && !mem_busy_i && !rst_i;
    assign bubble_e_o    = bubble && !mem_busy_i && !rst_i;
    assign flush_d_o     = flush  && !mem_busy_i && !rst_i;
    assign fwd_a_sel_o   = fwd_a_q;
    assign fwd_b_sel_o   = fwd_b_q;
    assign fwd_mem_sel_o = fwd_mem_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, d_valid, d_use1, d_use2, d_reg_write, d_mem_read, d_mem_write;
    logic       e_br_taken, mem_busy;
    logic [4:0] d_addr1, d_addr2, d_waddr;
    logic       stall_fd, bubble_e, flush_d, freeze, fwd_mem_sel;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    int total = 0;
    int bad   = 0;

    hazard_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .d_valid_i     (d_valid),
        .d_addr1_i     (d_addr1),
        .d_addr2_i     (d_addr2),
        .d_use1_i      (d_use1),
        .d_use2_i      (d_use2),
        .d_waddr_i     (d_waddr),
        .d_reg_write_i (d_reg_write),
        .d_mem_read_i  (d_mem_read),
        .d_mem_write_i (d_mem_write),
        .e_br_taken_i  (e_br_taken),
        .mem_busy_i    (mem_busy),
        .stall_fd_o    (stall_fd),
        .bubble_e_o    (bubble_e),
        .flush_d_o     (flush_d),
        .freeze_o      (freeze),
        .fwd_a_sel_o   (fwd_a_sel),
        .fwd_b_sel_o   (fwd_b_sel),
        .fwd_mem_sel_o (fwd_mem_sel)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic [4:0] wa, input logic rw, input logic ld,
                         input logic st, input logic [4:0] a1, input logic u1,
                         input logic [4:0] a2, input logic u2);
        d_valid = v; d_waddr = wa; d_reg_write = rw; d_mem_read = ld; d_mem_write = st;
        d_addr1 = a1; d_use1 = u1; d_addr2 = a2; d_use2 = u2;
        #1;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        set_d(1'b1, rd, 1'b1, 1'b0, 1'b0, rs1, 1'b1, rs2, 1'b1);
    endtask

    task automatic lw(input logic [4:0] rd, input logic [4:0] rs1);
        set_d(1'b1, rd, 1'b1, 1'b1, 1'b0, rs1, 1'b1, 5'd0, 1'b0);
    endtask

    task automatic sw(input logic [4:0] rs2, input logic [4:0] rs1);
        set_d(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, rs1, 1'b1, rs2, 1'b1);
    endtask

    task automatic nop;
        set_d(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic idle;
        rst = 1'b0; e_br_taken = 1'b0; mem_busy = 1'b0;
        nop;
        repeat (4) tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; e_br_taken = 1'b1; mem_busy = 1'b1;
        alu(5'd5, 5'd1, 5'd2);
        tick; tick;
        total++; if ({freeze, flush_d, bubble_e, stall_fd} !== 4'b0000) begin bad++;
            $display("FAIL reset_ctrl got=%b want=0000", {freeze, flush_d, bubble_e, stall_fd}); end
        total++; if ({fwd_a_sel, fwd_b_sel, fwd_mem_sel} !== 5'b0) begin bad++;
            $display("FAIL reset_fwd got a=%0d b=%0d m=%0d want 0", fwd_a_sel, fwd_b_sel, fwd_mem_sel); end
        idle;
    endtask

    task automatic test_fwd_e;
        idle;
        alu(5'd5, 5'd1, 5'd2); tick;
        alu(5'd6, 5'd5, 5'd5);
        total++; if ({stall_fd, bubble_e} !== 2'b00) begin bad++;
            $display("FAIL fwd_e_stall got=%b want=00", {stall_fd, bubble_e}); end
        tick;
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0101) begin bad++;
            $display("FAIL fwd_e got a=%0d b=%0d want a=1 b=1", fwd_a_sel, fwd_b_sel); end
    endtask

    task automatic test_fwd_m;
        idle;
        alu(5'd5, 5'd1, 5'd2); tick;
        nop; tick;
        alu(5'd7, 5'd5, 5'd1);
        total++; if (stall_fd !== 1'b0) begin bad++;
            $display("FAIL fwd_m_stall got=%b want=0", stall_fd); end
        tick;
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1000) begin bad++;
            $display("FAIL fwd_m got a=%0d b=%0d want a=2 b=0", fwd_a_sel, fwd_b_sel); end
    endtask

    task automatic test_load_use;
        idle;
        lw(5'd5, 5'd9); tick;
        alu(5'd6, 5'd5, 5'd0);
        total++; if ({stall_fd, bubble_e} !== 2'b11) begin bad++;
            $display("FAIL lu_first got=%b want=11", {stall_fd, bubble_e}); end
        tick;
        total++; if ({stall_fd, bubble_e, fwd_a_sel} !== 4'b0000) begin bad++;
            $display("FAIL lu_second got stall=%b bub=%b a=%0d want 0 0 0", stall_fd, bubble_e, fwd_a_sel); end
        tick;
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1000) begin bad++;
            $display("FAIL lu_fwd got a=%0d b=%0d want a=2 b=0", fwd_a_sel, fwd_b_sel); end
    endtask

    task automatic test_load_store;
        idle;
        lw(5'd5, 5'd9); tick;
        sw(5'd5, 5'd9);
        total++; if (stall_fd !== 1'b0) begin bad++;
            $display("FAIL ldst_stall got=%b want=0", stall_fd); end
        tick;
        nop;
        total++; if ({fwd_mem_sel, fwd_b_sel} !== 3'b000) begin bad++;
            $display("FAIL ldst_e got m=%0d b=%0d want 0 0", fwd_mem_sel, fwd_b_sel); end
        tick;
        total++; if (fwd_mem_sel !== 1'b1) begin bad++;
            $display("FAIL ldst_m got=%b want=1", fwd_mem_sel); end
        tick;
        total++; if (fwd_mem_sel !== 1'b0) begin bad++;
            $display("FAIL ldst_w got=%b want=0", fwd_mem_sel); end
        idle;
        lw(5'd5, 5'd9); tick;
        sw(5'd9, 5'd5);
        total++; if (stall_fd !== 1'b1) begin bad++;
            $display("FAIL st_base_stall got=%b want=1", stall_fd); end
    endtask

    task automatic test_freeze_flush;
        idle;
        lw(5'd5, 5'd9); tick;
        alu(5'd6, 5'd5, 5'd1);
        mem_busy = 1'b1; #1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin e_br_taken = 1'b1; #1; end
            total++; if ({freeze, flush_d, bubble_e, stall_fd} !== 4'b1000) begin bad++;
                $display("FAIL freeze_%0d got=%b want=1000", c, {freeze, flush_d, bubble_e, stall_fd}); end
            tick;
        end
        e_br_taken = 1'b0; mem_busy = 1'b0; #1;
        total++; if ({stall_fd, bubble_e} !== 2'b11) begin bad++;
            $display("FAIL unfreeze_stall got=%b want=11", {stall_fd, bubble_e}); end
        tick;
        total++; if (stall_fd !== 1'b0) begin bad++;
            $display("FAIL single_bubble got=%b want=0", stall_fd); end
        tick;
        total++; if (fwd_a_sel !== 2'd2) begin bad++;
            $display("FAIL freeze_fwd got=%0d want=2", fwd_a_sel); end
        idle;
        lw(5'd5, 5'd9); tick;
        alu(5'd6, 5'd5, 5'd1);
        e_br_taken = 1'b1; #1;
        total++; if ({flush_d, bubble_e, stall_fd} !== 3'b110) begin bad++;
            $display("FAIL flush got=%b want=110", {flush_d, bubble_e, stall_fd}); end
        tick;
        e_br_taken = 1'b0; #1;
        total++; if (stall_fd !== 1'b0) begin bad++;
            $display("FAIL post_flush_stall got=%b want=0", stall_fd); end
        tick;
        total++; if (fwd_a_sel !== 2'd2) begin bad++;
            $display("FAIL post_flush_fwd got=%0d want=2", fwd_a_sel); end
    endtask

    task automatic test_x0_and_reset;
        idle;
        alu(5'd0, 5'd1, 5'd2); tick;
        alu(5'd1, 5'd0, 5'd0);
        total++; if (stall_fd !== 1'b0) begin bad++;
            $display("FAIL x0_stall got=%b want=0", stall_fd); end
        tick;
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin bad++;
            $display("FAIL x0_fwd got a=%0d b=%0d want 0 0", fwd_a_sel, fwd_b_sel); end
        lw(5'd5, 5'd9); tick;
        alu(5'd6, 5'd5, 5'd1);
        total++; if (stall_fd !== 1'b1) begin bad++;
            $display("FAIL pre_rst_stall got=%b want=1", stall_fd); end
        rst = 1'b1;
        tick;
        rst = 1'b0; #1;
        total++; if ({freeze, flush_d, bubble_e, stall_fd, fwd_a_sel, fwd_b_sel, fwd_mem_sel} !== 9'b0) begin bad++;
            $display("FAIL rst_mid_stall got ctrl=%b a=%0d b=%0d", {freeze, flush_d, bubble_e, stall_fd}, fwd_a_sel, fwd_b_sel); end
        tick;
        total++; if (fwd_a_sel !== 2'd0) begin bad++;
            $display("FAIL rst_slots_clear got=%0d want=0", fwd_a_sel); end
    endtask

    // Reference: each in-flight instruction (E, M, W) carries the selects it was
    // granted on entering E and whether its store data comes from the load ahead.
    task automatic test_random;
        logic       mv[3], mwr[3], mld[3], mldst[3];
        logic [4:0] mrd[3];
        logic [1:0] msa[3], msb[3];
        logic       hold, nr1, nr2, ls, hz;
        int         j1, j2, kind;
        logic [1:0] sa, sb;
        logic [3:0] exp_c;
        logic [4:0] exp_r;
        idle;
        for (int k = 0; k < 3; k++) begin
            mv[k] = 0; mwr[k] = 0; mld[k] = 0; mldst[k] = 0; mrd[k] = 0; msa[k] = 0; msb[k] = 0;
        end
        hold = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 299) == 0);
            mem_busy   = ($urandom_range(0, 9) == 0);
            e_br_taken = ($urandom_range(0, 19) == 0);
            if (!hold) begin
                kind = $urandom_range(0, 3);
                set_d($urandom_range(0, 6) != 0, 5'($urandom_range(0, 3)), kind < 2, kind == 1,
                      kind == 2, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)) | (kind == 2),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end else begin
                #1;
            end
            j1 = -1; j2 = -1;
            for (int k = 2; k >= 0; k--) begin
                if (d_valid && d_use1 && d_addr1 != 0 && mv[k] && mwr[k] && mrd[k] == d_addr1) j1 = k;
                if (d_valid && d_use2 && d_addr2 != 0 && mv[k] && mwr[k] && mrd[k] == d_addr2) j2 = k;
            end
            nr1 = (j1 == 0) && mld[0];
            nr2 = (j2 == 0) && mld[0];
            ls  = d_mem_write && nr2;
            hz  = nr1 || (nr2 && !ls);
            sa  = (j1 >= 0 && !nr1 && j1 < 2) ? 2'(j1 + 1) : 2'd0;
            sb  = (j2 >= 0 && !nr2 && j2 < 2) ? 2'(j2 + 1) : 2'd0;
            if (rst)             exp_c = 4'b0000;
            else if (mem_busy)   exp_c = 4'b1000;
            else if (e_br_taken) exp_c = 4'b0110;
            else if (hz)         exp_c = 4'b0011;
            else                 exp_c = 4'b0000;
            total++; if ({freeze, flush_d, bubble_e, stall_fd} !== exp_c) begin bad++;
                $display("FAIL rand_ctrl cyc=%0d got=%b want=%b", n, {freeze, flush_d, bubble_e, stall_fd}, exp_c); end
            if (rst) begin
                for (int k = 0; k < 3; k++) begin mv[k] = 0; msa[k] = 0; msb[k] = 0; mldst[k] = 0; end
            end else if (!mem_busy) begin
                for (int k = 2; k > 0; k--) begin
                    mv[k] = mv[k-1]; mwr[k] = mwr[k-1]; mld[k] = mld[k-1]; mrd[k] = mrd[k-1];
                    msa[k] = msa[k-1]; msb[k] = msb[k-1]; mldst[k] = mldst[k-1];
                end
                if (e_br_taken || hz || !d_valid) begin
                    mv[0] = 0; mwr[0] = 0; mld[0] = 0; mrd[0] = 0; msa[0] = 0; msb[0] = 0; mldst[0] = 0;
                end else begin
                    mv[0] = 1; mwr[0] = d_reg_write; mld[0] = d_mem_read; mrd[0] = d_waddr;
                    msa[0] = sa; msb[0] = sb; mldst[0] = ls;
                end
            end
            hold = !rst && (mem_busy || (!e_br_taken && hz));
            tick;
            exp_r = {msa[0], msb[0], mldst[1]};
            total++; if ({fwd_a_sel, fwd_b_sel, fwd_mem_sel} !== exp_r) begin bad++;
                $display("FAIL rand_fwd cyc=%0d got a=%0d b=%0d m=%0d want a=%0d b=%0d m=%0d", n,
                         fwd_a_sel, fwd_b_sel, fwd_mem_sel, exp_r[4:3], exp_r[2:1], exp_r[0]); end
        end
        rst = 1'b0; mem_busy = 1'b0; e_br_taken = 1'b0;
    endtask

    initial begin
        rst = 1'b1; e_br_taken = 1'b0; mem_busy = 1'b0;
        d_valid = 1'b0; d_addr1 = '0; d_addr2 = '0; d_use1 = 1'b0; d_use2 = 1'b0;
        d_waddr = '0; d_reg_write = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
        test_reset;
        test_fwd_e;
        test_fwd_m;
        test_load_use;
        test_load_store;
        test_freeze_flush;
        test_x0_and_reset;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
